// File: rtl/knn_pkg.sv
// knn_pkg: shared parameters and types for the KNN sample loader.
//   DEPTH / ADDR_W  : sample memory size and address width
//   FEAT_W / LABEL_W: feature and class label widths
//   state_t         : loader FSM encoding
//   sample_t        : stored sample word {label, feature}
package knn_pkg;

    localparam int DEPTH      = 128;
    localparam int ADDR_W     = 7;
    localparam int FEAT_W     = 8;
    localparam int LABEL_W    = 2;
    localparam int COUNT_W    = ADDR_W + 1;
    localparam int SAMPLE_W   = LABEL_W + FEAT_W;
    localparam int NUM_LABELS = 1 << LABEL_W;
    localparam int HIST_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LABEL = 2'b01,
        FEAT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef struct packed {
        logic [LABEL_W-1:0] label;
        logic [FEAT_W-1:0]  feature;
    } sample_t;

endpackage

// File: rtl/knn_sample_mem.sv
// knn_sample_mem: DEPTH x SAMPLE_W sample store, contents not reset.
//   clk     : write clock (rising edge)
//   we      : write enable
//   wr_addr : write address
//   wr_data : sample word written at the clock edge
//   rd_addr : read address
//   rd_data : combinational read of mem[rd_addr]
module knn_sample_mem
    import knn_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  sample_t           wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output sample_t           rd_data
);

    sample_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/knn_sample_loader.sv
// knn_sample_loader: receives {label byte, feature byte} pairs over a valid/ready
// byte stream, stores them in the sample memory and pulses knn_start when the
// dataset is complete (in_last on a feature byte, or memory full).
//   clk, rst      : clock, asynchronous active-high reset
//   load_start    : clear count and (re)start a load; beats priority-lost to it
//   in_valid/in_data/in_last/in_ready : byte stream handshake
//   rd_addr/rd_data/rd_hit : combinational scan port for the distance unit
//   sample_count  : samples stored (0..DEPTH)
//   load_done     : level, dataset complete
//   knn_start     : one-cycle pulse on entry to DONE
//   label_hist    : per-label sample counts {l3,l2,l1,l0}, built only when
//                   KNN_LOADER_HIST_EN is defined, otherwise tied to 0
//
// state | meaning
// IDLE  | waiting for load_start
// LABEL | expecting the label byte of the next sample
// FEAT  | expecting the feature byte; completes and stores the sample
// DONE  | dataset complete, stream refused until load_start
module knn_sample_loader
    import knn_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    input  logic                in_last,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                rd_hit,
    output logic [COUNT_W-1:0]  sample_count,
    output logic                load_done,
    output logic                knn_start,
    output logic [4*8-1:0]      label_hist
);

    state_t             state;
    logic [LABEL_W-1:0] label_q;
    logic               beat;
    logic               wr_en;
    sample_t            wr_word;
    sample_t            rd_word;

    assign beat    = in_valid && in_ready;
    // load_start wins over a simultaneous feature beat, so that beat is not stored
    assign wr_en   = (state == FEAT) && beat && !load_start;
    assign wr_word = '{label: label_q, feature: in_data[FEAT_W-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            load_done    <= 1'b0;
            knn_start    <= 1'b0;
            sample_count <= '0;
            label_q      <= '0;
        end else begin
            knn_start <= 1'b0;
            if (load_start) begin
                state        <= LABEL;
                in_ready     <= 1'b1;
                load_done    <= 1'b0;
                sample_count <= '0;
            end else begin
                case (state)
                    IDLE: ;
                    LABEL: begin
                        if (beat) begin
                            label_q <= in_data[LABEL_W-1:0];
                            state   <= FEAT;
                        end
                    end
                    FEAT: begin
                        if (beat) begin
                            sample_count <= sample_count + 1'b1;
                            if (in_last || sample_count == COUNT_W'(DEPTH - 1)) begin
                                state     <= DONE;
                                in_ready  <= 1'b0;
                                load_done <= 1'b1;
                                knn_start <= 1'b1;
                            end else begin
                                state <= LABEL;
                            end
                        end
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    knn_sample_mem u_mem (
        .clk     (clk),
        .we      (wr_en),
        .wr_addr (sample_count[ADDR_W-1:0]),
        .wr_data (wr_word),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    assign rd_data = rd_word;
    assign rd_hit  = {1'b0, rd_addr} < sample_count;

`ifdef KNN_LOADER_HIST_EN
    logic [HIST_W-1:0] hist [NUM_LABELS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LABELS; i++) begin
                hist[i] <= '0;
            end
        end else if (load_start) begin
            for (int i = 0; i < NUM_LABELS; i++) begin
                hist[i] <= '0;
            end
        end else if (wr_en && hist[label_q] != {HIST_W{1'b1}}) begin
            hist[label_q] <= hist[label_q] + 1'b1;
        end
    end

    assign label_hist = {hist[3], hist[2], hist[1], hist[0]};
`else
    assign label_hist = '0;
`endif

endmodule

// File: tb/tb_knn_sample_loader.sv
module tb_knn_sample_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic [6:0]  rd_addr;
    logic [9:0]  rd_data;
    logic        rd_hit;
    logic [7:0]  sample_count;
    logic        load_done;
    logic        knn_start;
    logic [31:0] label_hist;

    int checks = 0;
    int errors = 0;
    int start_pulses = 0;

    // reference: list of {label, feature} samples sent in the current load
    logic [9:0] ref_q[$];

    knn_sample_loader dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_hit       (rd_hit),
        .sample_count (sample_count),
        .load_done    (load_done),
        .knn_start    (knn_start),
        .label_hist   (label_hist)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (knn_start) start_pulses++;

    function automatic logic [31:0] ref_hist();
        logic [31:0] h = '0;
`ifdef KNN_LOADER_HIST_EN
        int cnt [4] = '{0, 0, 0, 0};
        foreach (ref_q[i]) cnt[ref_q[i][9:8]]++;
        for (int l = 0; l < 4; l++) h[l*8 +: 8] = (cnt[l] > 255) ? 8'd255 : 8'(cnt[l]);
`endif
        return h;
    endfunction

    task automatic pulse_load_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        start_pulses = 0;
    endtask

    // drive one byte at a negedge, hold until accepted (bounded)
    task automatic send_byte(input logic [7:0] d, input logic last, input int max_gap);
        int n = 0;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // send ref_q as one load; noise randomizes label byte upper bits and in_last on labels
    task automatic load_samples(input int max_gap, input bit use_last, input bit noise);
        logic [31:0] r;
        pulse_load_start();
        foreach (ref_q[i]) begin
            r = $urandom;
            if (noise) send_byte({r[5:0], ref_q[i][9:8]}, r[6], max_gap);
            else       send_byte({6'b0, ref_q[i][9:8]}, 1'b0, max_gap);
            send_byte(ref_q[i][7:0], use_last && (i == ref_q.size() - 1), max_gap);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_start = 0; in_valid = 0; in_data = 0; in_last = 0; rd_addr = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %0b want 0", load_done); end
        checks++; if (sample_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", sample_count); end
        checks++; if (knn_start !== 1'b0) begin errors++; $display("FAIL reset_knn_start: got %0b want 0", knn_start); end
        checks++; if (label_hist !== 32'h0) begin errors++; $display("FAIL reset_hist: got %h want 0", label_hist); end
    endtask

    task automatic test_basic(input int max_gap);
        ref_q = '{10'h15A, 10'h233, 10'h3F0};
        load_samples(max_gap, 1'b1, 1'b0);
        checks++; if (sample_count !== 8'd3) begin errors++; $display("FAIL basic_count gap%0d: got %0d want 3", max_gap, sample_count); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL basic_done gap%0d: got %0b want 1", max_gap, load_done); end
        checks++; if (start_pulses != 1) begin errors++; $display("FAIL basic_knn_start gap%0d: got %0d pulses want 1", max_gap, start_pulses); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready gap%0d: got %0b want 0", max_gap, in_ready); end
        for (int a = 0; a < 3; a++) begin
            rd_addr = 7'(a); #1;
            checks++; if (rd_data !== ref_q[a] || rd_hit !== 1'b1) begin
                errors++; $display("FAIL basic_mem[%0d] gap%0d: got %h hit %0b want %h hit 1", a, max_gap, rd_data, rd_hit, ref_q[a]);
            end
        end
        rd_addr = 7'd3; #1;
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL basic_hit3 gap%0d: got %0b want 0", max_gap, rd_hit); end
        checks++; if (label_hist !== ref_hist()) begin errors++; $display("FAIL basic_hist gap%0d: got %h want %h", max_gap, label_hist, ref_hist()); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            int n = $urandom_range(40, 1);
            ref_q.delete();
            for (int i = 0; i < n; i++) ref_q.push_back(10'($urandom));
            load_samples(2, 1'b1, 1'b1);
            checks++; if (sample_count !== 8'(n) || load_done !== 1'b1) begin
                errors++; $display("FAIL rand_count t%0d: got %0d done %0b want %0d done 1", t, sample_count, load_done, n);
            end
            for (int a = 0; a <= n && a < 128; a++) begin
                rd_addr = 7'(a); #1;
                checks++;
                if (rd_hit !== (a < n)) begin
                    errors++; $display("FAIL rand_hit t%0d a%0d: got %0b want %0b", t, a, rd_hit, a < n);
                end else if (a < n && rd_data !== ref_q[a]) begin
                    errors++; $display("FAIL rand_mem t%0d a%0d: got %h want %h", t, a, rd_data, ref_q[a]);
                end
            end
            checks++; if (label_hist !== ref_hist()) begin errors++; $display("FAIL rand_hist t%0d: got %h want %h", t, label_hist, ref_hist()); end
        end
    endtask

    task automatic test_full();
        ref_q.delete();
        for (int i = 0; i < 128; i++) ref_q.push_back(10'($urandom));
        load_samples(0, 1'b0, 1'b0);
        checks++; if (sample_count !== 8'd128) begin errors++; $display("FAIL full_count: got %0d want 128", sample_count); end
        checks++; if (load_done !== 1'b1 || start_pulses != 1) begin
            errors++; $display("FAIL full_done: got done %0b pulses %0d want 1 1", load_done, start_pulses);
        end
        in_valid = 1'b1; in_data = 8'h03;
        repeat (5) @(negedge clk);
        checks++; if (in_ready !== 1'b0 || sample_count !== 8'd128) begin
            errors++; $display("FAIL full_refuse: got ready %0b count %0d want 0 128", in_ready, sample_count);
        end
        in_valid = 1'b0;
        for (int a = 0; a < 128; a++) begin
            rd_addr = 7'(a); #1;
            checks++; if (rd_data !== ref_q[a] || rd_hit !== 1'b1) begin
                errors++; $display("FAIL full_mem[%0d]: got %h hit %0b want %h hit 1", a, rd_data, rd_hit, ref_q[a]);
            end
        end
    endtask

    task automatic test_restart();
        pulse_load_start();
        send_byte(8'h02, 1'b0, 0);
        ref_q = '{10'h111};
        load_samples(0, 1'b1, 1'b0);
        rd_addr = 7'd0; #1;
        checks++; if (sample_count !== 8'd1) begin errors++; $display("FAIL restart_count: got %0d want 1", sample_count); end
        checks++; if (rd_data !== 10'h111) begin errors++; $display("FAIL restart_mem0: got %h want 111", rd_data); end
        checks++; if (label_hist !== ref_hist()) begin errors++; $display("FAIL restart_hist: got %h want %h", label_hist, ref_hist()); end
    endtask

    // load_start together with a feature beat: the beat must not be stored
    task automatic test_priority();
        pulse_load_start();
        send_byte(8'h01, 1'b0, 0);
        in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1; load_start = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; load_start = 1'b0;
        checks++; if (sample_count !== 8'd0 || in_ready !== 1'b1 || load_done !== 1'b0) begin
            errors++; $display("FAIL priority: got count %0d ready %0b done %0b want 0 1 0", sample_count, in_ready, load_done);
        end
    endtask

    task automatic test_rst_mid_load();
        ref_q = '{10'h0C1, 10'h2D2};
        load_samples(0, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        rd_addr = 7'd0; #1;
        checks++; if (in_ready !== 1'b0 || load_done !== 1'b0 || knn_start !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags: got ready %0b done %0b start %0b want 0 0 0", in_ready, load_done, knn_start);
        end
        checks++; if (sample_count !== 8'd0 || rd_hit !== 1'b0 || label_hist !== 32'h0) begin
            errors++; $display("FAIL rst_mid_state: got count %0d hit %0b hist %h want 0 0 0", sample_count, rd_hit, label_hist);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic(0);
        test_basic(3);
        test_random();
        test_full();
        test_restart();
        test_priority();
        test_rst_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
